// File: rtl/rr_arb6_sel.sv
// Six-requester round-robin arbiter with a registered one-hot grant,
// a registered binary select for a downstream 6:1 mux, and a hold limit
// that force-releases an owner after MAX_HOLD consecutive grant cycles.
module rr_arb6_sel #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [5:0] req,
  output logic [5:0] gnt,
  output logic [2:0] sel,
  output logic       busy,
  output logic       expire
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state, state_nx;
  logic [2:0] ptr, ptr_nx;
  logic [2:0] sel_nx;
  logic [5:0] gnt_nx;
  logic [7:0] hold_cnt, hold_nx;
  logic       expire_nx;
  logic       found;
  logic [2:0] winner;
  logic [3:0] cand;

  // Round-robin search: first set request bit starting just after ptr, wrapping 5->0.
  always_comb begin
    found  = 1'b0;
    winner = 3'd0;
    cand   = 4'd0;
    for (int k = 1; k <= 6; k++) begin
      cand = {1'b0, ptr} + 4'(k);
      if (cand >= 4'd6) cand = cand - 4'd6;
      if (!found && req[cand[2:0]]) begin
        found  = 1'b1;
        winner = cand[2:0];
      end
    end
  end

  // Next-state logic: new grants only from IDLE; a grant ends on owner release or hold limit.
  always_comb begin
    state_nx  = state;
    gnt_nx    = gnt;
    sel_nx    = sel;
    ptr_nx    = ptr;
    hold_nx   = hold_cnt;
    expire_nx = 1'b0;
    case (state)
      IDLE: begin
        gnt_nx  = 6'b000000;
        hold_nx = 8'd0;
        if (en && found) begin
          state_nx = GRANT;
          gnt_nx   = 6'b000001 << winner;
          sel_nx   = winner;
          ptr_nx   = winner;
        end
      end
      GRANT: begin
        if (!req[sel]) begin
          state_nx = IDLE;
          gnt_nx   = 6'b000000;
          hold_nx  = 8'd0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nx  = IDLE;
          gnt_nx    = 6'b000000;
          hold_nx   = 8'd0;
          expire_nx = 1'b1;
        end else begin
          hold_nx = hold_cnt + 8'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = 6'b000000;
        hold_nx  = 8'd0;
      end
    endcase
  end

  // State and output registers; reset points ptr at 5 so the first search starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= 6'b000000;
      sel      <= 3'd0;
      ptr      <= 3'd5;
      hold_cnt <= 8'd0;
      expire   <= 1'b0;
    end else begin
      state    <= state_nx;
      gnt      <= gnt_nx;
      sel      <= sel_nx;
      ptr      <= ptr_nx;
      hold_cnt <= hold_nx;
      expire   <= expire_nx;
    end
  end

  assign busy = |gnt;

endmodule
